// File: rtl/dac_frame_sequencer_if.sv
// dac_frame_sequencer_if: sample-frame input plus the DAC serialiser Send/Ready handshake.
interface dac_frame_sequencer_if #(parameter int NUM_CH = 4);
    logic                 strobe;
    logic [16*NUM_CH-1:0] samples;
    logic [NUM_CH-1:0]    ch_enable;
    logic                 dac_ready;
    logic [23:0]          dac_data;
    logic                 dac_send;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;
    logic                 timeout;
    modport master (input strobe, samples, ch_enable, dac_ready,
                    output dac_data, dac_send, busy, frame_done, overrun, timeout);
    modport slave (output strobe, samples, ch_enable, dac_ready,
                   input dac_data, dac_send, busy, frame_done, overrun, timeout);
endinterface

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: latches a frame of per-channel samples and feeds them as {cmd,addr,data}
// words to the SPI DAC serialiser, the last enabled channel carrying the update command.
module dac_frame_sequencer #(
    parameter int         NUM_CH     = 4,
    parameter logic [3:0] WRITE_CMD  = 4'h1,
    parameter logic [3:0] UPDATE_CMD = 4'h3,
    parameter logic [7:0] TIMEOUT    = 8'd255
) (
    input logic i_Clock,
    input logic i_Reset,
    dac_frame_sequencer_if.master bus
);
    localparam int PW = $clog2(NUM_CH + 1);
    typedef enum logic [2:0] {IDLE, LOAD, REQUEST, WAIT_DONE, DONE} state_t;
    state_t               state;
    logic [16*NUM_CH-1:0] act_samples, pend_samples;
    logic [NUM_CH-1:0]    act_en, pend_en;
    logic                 pend_full, seen_high;
    logic [PW-1:0]        ch_ptr, cur_ch, sel;
    logic [7:0]           cnt;
    logic                 found, higher;
    logic [3:0]           addr;
    logic [15:0]          data;

    // lowest enabled channel at or above ch_ptr, and whether any enabled channel follows it
    always_comb begin
        found = 1'b0;
        higher = 1'b0;
        sel = '0;
        addr = '0;
        data = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (act_en[n] && PW'(n) >= ch_ptr) begin
                if (found) higher = 1'b1;
                else begin
                    found = 1'b1;
                    sel = PW'(n);
                    addr = 4'(1 << n);
                    data = act_samples[16*n +: 16];
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
            pend_full <= 1'b0;
            seen_high <= 1'b0;
            ch_ptr <= '0;
            cur_ch <= '0;
            cnt <= '0;
            bus.dac_data <= '0;
            bus.dac_send <= 1'b0;
            bus.busy <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.overrun <= bus.strobe && bus.busy && pend_full && state != DONE;
            case (state)
                IDLE: if (bus.strobe || pend_full) begin
                    act_samples <= bus.strobe ? bus.samples : pend_samples;
                    act_en <= bus.strobe ? bus.ch_enable : pend_en;
                    if (!bus.strobe) pend_full <= 1'b0;
                    ch_ptr <= '0;
                    bus.busy <= 1'b1;
                    state <= LOAD;
                end
                LOAD: if (found) begin
                    bus.dac_data <= {higher ? WRITE_CMD : UPDATE_CMD, addr, data};
                    bus.dac_send <= 1'b1;
                    cur_ch <= sel;
                    cnt <= '0;
                    seen_high <= 1'b0;
                    state <= REQUEST;
                end else begin
                    bus.frame_done <= 1'b1;
                    state <= DONE;
                end
                // a low Ready only counts as acceptance once Ready was seen high in this request
                REQUEST: if (!bus.dac_ready && seen_high) begin
                    bus.dac_send <= 1'b0;
                    cnt <= '0;
                    state <= WAIT_DONE;
                end else if (cnt == TIMEOUT) begin
                    bus.timeout <= 1'b1;
                    bus.dac_send <= 1'b0;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 8'd1;
                    seen_high <= seen_high | bus.dac_ready;
                end
                WAIT_DONE: if (bus.dac_ready) begin
                    ch_ptr <= cur_ch + PW'(1);
                    state <= LOAD;
                end else if (cnt == TIMEOUT) begin
                    bus.timeout <= 1'b1;
                    state <= DONE;
                end else cnt <= cnt + 8'd1;
                DONE: if (pend_full) begin
                    act_samples <= pend_samples;
                    act_en <= pend_en;
                    pend_full <= 1'b0;
                    ch_ptr <= '0;
                    state <= LOAD;
                end else begin
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.strobe && bus.busy) begin
                pend_samples <= bus.samples;
                pend_en <= bus.ch_enable;
                pend_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: directed frames against a behavioural serialiser; accepted words are
// checked in order against a queue of expected words built from each strobed frame.
module tb_dac_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0, fails = 0;
    int          mode = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got_mem[256];
    int          got_wr = 0, rd = 0;
    int          fd_cnt = 0, ov_cnt = 0, busy_low = 0, send_rise = 0, drop_err = 0, ser_cnt = 0;
    logic        odd = 1'b0, prev_send = 1'b0, prev_ready = 1'b1, prev_rst = 1'b1;

    dac_frame_sequencer_if #(.NUM_CH(4)) bus();
    dac_frame_sequencer dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // serialiser model: mode 0 accepts Send at once, mode 1 only on odd cycles, mode 2 never
    always @(posedge clk) begin
        odd <= ~odd;
        prev_send <= bus.dac_send;
        prev_ready <= bus.dac_ready;
        prev_rst <= rst;
        if (bus.frame_done) fd_cnt <= fd_cnt + 1;
        if (bus.overrun) ov_cnt <= ov_cnt + 1;
        if (!bus.busy) busy_low <= busy_low + 1;
        if (bus.dac_send && !prev_send) send_rise <= send_rise + 1;
        if (prev_send && !bus.dac_send && prev_ready && !prev_rst && !bus.timeout) drop_err <= drop_err + 1;
        if (rst) begin
            bus.dac_ready <= 1'b1;
            ser_cnt <= 0;
        end else if (ser_cnt != 0) begin
            ser_cnt <= ser_cnt - 1;
            if (ser_cnt == 1) bus.dac_ready <= 1'b1;
        end else if (mode != 2 && bus.dac_send && bus.dac_ready && (mode == 0 || odd)) begin
            bus.dac_ready <= 1'b0;
            ser_cnt <= 4;
            got_mem[got_wr[7:0]] <= bus.dac_data;
            got_wr <= got_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [63:0] s, input logic [3:0] m);
        int last = -1;
        for (int n = 0; n < 4; n++) if (m[n]) last = n;
        for (int n = 0; n < 4; n++)
            if (m[n]) exp_q.push_back({n == last ? 4'h3 : 4'h1, 4'(1 << n), s[16*n +: 16]});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_frame(input logic [63:0] s, input logic [3:0] m);
        @(negedge clk);
        bus.strobe = 1'b1;
        bus.samples = s;
        bus.ch_enable = m;
        @(negedge clk);
        bus.strobe = 1'b0;
        bus.samples = '1;
        bus.ch_enable = '1;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n = 0;
        while (fd_cnt < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " frame_done count"}, fd_cnt, target);
    endtask

    task automatic check_words(input string tag);
        chk({tag, " word count"}, got_wr - rd, exp_q.size());
        while (exp_q.size() > 0 && rd < got_wr) begin
            chk({tag, " word"}, got_mem[rd[7:0]], exp_q.pop_front());
            rd++;
        end
        exp_q.delete();
        rd = got_wr;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " data"}, bus.dac_data, 0);
        chk({tag, " send"}, bus.dac_send, 0);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " frame_done"}, bus.frame_done, 0);
        chk({tag, " overrun"}, bus.overrun, 0);
        chk({tag, " timeout"}, bus.timeout, 0);
    endtask

    initial begin
        int snap, snap2, n;
        logic [63:0] s;
        bus.strobe = 1'b0;
        bus.samples = '0;
        bus.ch_enable = '0;
        tick(3);
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        push_frame(64'h4444_3333_2222_1111, 4'hF);
        strobe_frame(64'h4444_3333_2222_1111, 4'hF);
        wait_fd(1, "t1");
        check_words("t1");
        tick(2);
        chk("t1 busy after", bus.busy, 0);

        push_frame(64'h5678_BBBB_1234_AAAA, 4'b0101);
        strobe_frame(64'h5678_BBBB_1234_AAAA, 4'b0101);
        wait_fd(2, "t2");
        check_words("t2");

        snap = send_rise;
        strobe_frame(64'hDEAD_BEEF_CAFE_F00D, 4'h0);
        tick(1);
        chk("t2 mask0 frame_done", bus.frame_done, 1);
        tick(1);
        chk("t2 mask0 pulse width", bus.frame_done, 0);
        chk("t2 mask0 frame_done count", fd_cnt, 3);
        chk("t2 mask0 no send", send_rise - snap, 0);
        chk("t2 data held", bus.dac_data, 24'h34BBBB);

        push_frame(64'h0D0D_0C0C_0B0B_0A0A, 4'hF);
        strobe_frame(64'h0D0D_0C0C_0B0B_0A0A, 4'hF);
        snap = busy_low;
        snap2 = ov_cnt;
        tick(3);
        strobe_frame(64'h1111_2222_3333_4444, 4'b0011);
        tick(2);
        push_frame(64'h9999_8888_7777_6666, 4'b1001);
        strobe_frame(64'h9999_8888_7777_6666, 4'b1001);
        wait_fd(5, "t3");
        chk("t3 busy low cycles", busy_low - snap, 0);
        chk("t3 overrun pulses", ov_cnt - snap2, 1);
        check_words("t3");

        tick(3);
        mode = 2;
        snap = fd_cnt;
        strobe_frame(64'h4444_3333_2222_1111, 4'hF);
        tick(100);
        chk("t4 early timeout", bus.timeout, 0);
        chk("t4 send held", bus.dac_send, 1);
        n = 0;
        while (!bus.timeout && n < 400) begin
            tick(1);
            n++;
        end
        chk("t4 timeout", bus.timeout, 1);
        chk("t4 send dropped", bus.dac_send, 0);
        tick(3);
        chk("t4 busy", bus.busy, 0);
        chk("t4 no frame_done", fd_cnt - snap, 0);
        chk("t4 no words", got_wr - rd, 0);
        tick(20);
        chk("t4 timeout sticky", bus.timeout, 1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        chk("t5 timeout cleared", bus.timeout, 0);
        strobe_frame(64'h5555_5555_5555_5555, 4'hF);
        n = 0;
        while (got_wr - rd < 2 && n < 500) begin
            tick(1);
            n++;
        end
        chk("t5 second word accepted", got_wr - rd, 2);
        n = 0;
        while (bus.dac_send && n < 50) begin
            tick(1);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        check_reset("t5 mid-frame reset");
        @(negedge clk);
        rst = 1'b0;
        rd = got_wr;
        snap = fd_cnt;
        push_frame(64'h6666_7777_8888_9999, 4'hF);
        strobe_frame(64'h6666_7777_8888_9999, 4'hF);
        wait_fd(snap + 1, "t5");
        check_words("t5");

        mode = 1;
        s = {$urandom, $urandom};
        push_frame(s, 4'hF);
        strobe_frame(s, 4'hF);
        wait_fd(snap + 2, "t6a");
        check_words("t6a");
        s = {$urandom, $urandom};
        push_frame(s, 4'b1110);
        strobe_frame(s, 4'b1110);
        wait_fd(snap + 3, "t6b");
        check_words("t6b");
        chk("t6 early send drops", drop_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
